styler_pixel_serializer: RTL and testbench
==========================================

// Module: styler_pixel_serializer
// PURPOSE
//  Downstream of the character styler. Takes each styled glyph row (bitmap word) on a valid/ready
//  handshake and shifts it out one pixel per pixel strobe, MSB first. Optional 2x horizontal pixel
//  repeat. Two-deep buffering (holding reg + shift reg): the next row loads with no pixel gap.
// PARAMETERS
//  WIDTH  16  pixels per input word (bitmap row width)
//  CNTW   $clog2(2*WIDTH)  strobe counter width (derived; do not override)
// PORTS
//  clk        in   1      clock; all state on rising edge
//  rst_n      in   1      asynchronous active-low reset
//  flush      in   1      synchronous clear of all buffered data
//  in_valid   in   1      input word valid
//  in_ready   out  1      holding register empty; word accepted when in_valid & in_ready
//  in_bits    in   WIDTH  styled bitmap row; bit WIDTH-1 is leftmost pixel
//  in_hscale  in   1      1 = each pixel held for 2 strobes; sampled with the word
//  in_last    in   1      word is the last of a scanline; sampled with the word
//  pix_en     in   1      pixel strobe; one pixel period consumed per strobe
//  pix_out    out  1      current pixel (0 when pix_valid=0)
//  pix_valid  out  1      shift register holds a word
//  pix_last   out  1      final pixel period of a word tagged in_last
//  underrun   out  1      registered one-cycle pulse: pix_en seen while pix_valid=0
// BEHAVIOUR
//  State: HR {bits, hscale, last, full}; SR {bits, hscale, last, full, cnt[CNTW-1:0]}.
//  Reset (rst_n=0, async) and flush (sync, highest priority): HR.full=SR.full=0, cnt=0, underrun=0.
//   Outputs during/after reset: in_ready=1, pix_out=0, pix_valid=0, pix_last=0, underrun=0.
//  in_ready = ~HR.full (from registered state only; no combinational path from pix_en).
//  Accept: in_valid & in_ready at edge N -> HR.full=1 after edge N.
//  Strobe "done": pix_en & SR.full & cnt == WIDTH*(1+SR.hscale)-1.
//  Transfer HR->SR at an edge when HR.full & (~SR.full | done); HR.full clears, cnt=0.
//   Latency: word accepted at edge N with SR idle -> pix_valid=1 after edge N+1.
//   Transfer on the done edge gives zero-bubble continuation.
//   HR accept and HR->SR transfer on the same edge is impossible (in_ready=0 while HR.full).
//  Per pix_en with SR.full: cnt+=1; if hscale=0 shift SR.bits left 1 each strobe;
//   if hscale=1 shift on odd cnt only. done without transfer -> SR.full=0.
//  pix_out = SR.full & SR.bits[WIDTH-1]; pix_valid = SR.full.
//  pix_last = SR.full & SR.last & (cnt >= WIDTH*(1+SR.hscale)-1-SR.hscale), i.e. the last pixel
//   period: 1 strobe if hscale=0, 2 strobes if hscale=1.
//  pix_en with SR.full=0: no state change except underrun=1 for the following cycle.
//   Deasserted on the next cycle without pix_en.
//  pix_en=0: SR holds; pix_out stable.
//  rst_n assertion mid-word discards both buffers immediately, without waiting for clk.
// TESTING
//  T1 reset: rst_n=0 with no clock -> in_ready=1, pix_valid=0, pix_out=0, underrun=0.
//  T2 in_bits=16'hA5C3, hscale=0, last=0, pix_en=1 every cycle -> pix_out=1010010111000011.
//     pix_valid high 16 cycles starting 2 cycles after accept; pix_last never set.
//  T3 in_bits=16'h8001, hscale=1, last=1 -> pix_out 1,1, then 28 zeros, then 1,1.
//     pix_last high only on the final 2 strobes.
//  T4 three words 16'hFFFF,16'h0000,16'hF0F0 with in_valid held, pix_en=1 -> 48 contiguous pixels.
//     No pix_valid gap; in_ready low while HR full.
//  T5 pix_en=1 with buffers empty -> underrun=1 for exactly one cycle after each strobe.
//     pix_out=0; no pixels emitted.
//  T6 flush after 5 pixels of a word, another word in HR -> next cycle pix_valid=0, in_ready=1.
//     Neither word resumes; repeat with async rst_n pulse between clock edges -> same result.

Source files
------------

// File: rtl/styler_pixel_serializer.sv
// Styled glyph-row serializer: holding reg + shift reg, one pixel per strobe, MSB first.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_bits/in_hscale/in_last, pix_en, pix_out/valid/last, underrun.
module styler_pixel_serializer #(
  parameter int WIDTH = 16,
  parameter int CNTW  = $clog2(2*WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_bits,
  input  logic             in_hscale,
  input  logic             in_last,
  input  logic             pix_en,
  output logic             pix_out,
  output logic             pix_valid,
  output logic             pix_last,
  output logic             underrun
);

  typedef struct packed {
    logic [WIDTH-1:0] bits;
    logic             hscale;
    logic             last;
    logic             full;
  } hr_t;

  typedef struct packed {
    logic [WIDTH-1:0] bits;
    logic             hscale;
    logic             last;
    logic             full;
    logic [CNTW-1:0]  cnt;
  } sr_t;

  hr_t hr_q, hr_d;
  sr_t sr_q, sr_d;
  logic und_q, und_d;

  logic [CNTW-1:0] end_cnt;
  logic [CNTW-1:0] last_cnt;
  logic            accept;
  logic            done;
  logic            xfer;
  logic            step;

  assign end_cnt  = sr_q.hscale ? CNTW'(2*WIDTH-1)
                                : CNTW'(WIDTH-1);
  // last pixel period spans two strobes when repeated
  assign last_cnt = sr_q.hscale ? CNTW'(2*WIDTH-2)
                                : CNTW'(WIDTH-1);

  assign accept = in_valid & ~hr_q.full;
  assign done   = pix_en & sr_q.full
                & (sr_q.cnt == end_cnt);
  assign xfer   = hr_q.full & (~sr_q.full | done);
  assign step   = pix_en & sr_q.full & ~xfer;

  always_comb begin
    hr_d  = hr_q;
    sr_d  = sr_q;
    und_d = pix_en & ~sr_q.full;
    if (accept) begin
      hr_d.bits   = in_bits;
      hr_d.hscale = in_hscale;
      hr_d.last   = in_last;
      hr_d.full   = 1'b1;
    end
    unique case (1'b1)
      xfer: begin
        hr_d.full   = 1'b0;
        sr_d.bits   = hr_q.bits;
        sr_d.hscale = hr_q.hscale;
        sr_d.last   = hr_q.last;
        sr_d.full   = 1'b1;
        sr_d.cnt    = '0;
      end
      step: begin
        sr_d.cnt = sr_q.cnt + 1'b1;
        // repeated pixels advance on every second strobe
        if (~sr_q.hscale | sr_q.cnt[0])
          sr_d.bits = {sr_q.bits[WIDTH-2:0], 1'b0};
        if (done)
          sr_d.full = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hr_q  <= '0;
      sr_q  <= '0;
      und_q <= 1'b0;
    end else if (flush) begin
      hr_q.full <= 1'b0;
      sr_q.full <= 1'b0;
      sr_q.cnt  <= '0;
      und_q     <= 1'b0;
    end else begin
      hr_q  <= hr_d;
      sr_q  <= sr_d;
      und_q <= und_d;
    end
  end

  assign in_ready  = ~hr_q.full;
  assign pix_valid = sr_q.full;
  assign pix_out   = sr_q.full & sr_q.bits[WIDTH-1];
  assign pix_last  = sr_q.full & sr_q.last
                   & (sr_q.cnt >= last_cnt);
  assign underrun  = und_q;

endmodule

// File: tb/tb_styler_pixel_serializer.sv
// Directed bench for styler_pixel_serializer.
// Words queued for send; expected pixels scoreboarded on accept, checked per strobe.
module tb_styler_pixel_serializer;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         flush = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_bits = '0;
  logic         in_hscale = 1'b0;
  logic         in_last = 1'b0;
  logic         pix_en = 1'b0;
  logic         pix_out;
  logic         pix_valid;
  logic         pix_last;
  logic         underrun;

  typedef struct {
    logic [W-1:0] bits;
    logic         hs;
    logic         last;
  } word_t;

  typedef struct {
    logic pix;
    logic last;
  } pix_t;

  word_t tx_q[$];
  pix_t  sb[$];
  int    total = 0;
  int    bad = 0;
  int    vcnt = 0;

  styler_pixel_serializer dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_bits(in_bits), .in_hscale(in_hscale),
    .in_last(in_last), .pix_en(pix_en),
    .pix_out(pix_out), .pix_valid(pix_valid),
    .pix_last(pix_last), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic push_word(input word_t w);
    int n;
    pix_t p;
    n = w.hs ? 2*W : W;
    for (int k = 0; k < n; k++) begin
      p.pix  = w.bits[W-1-(w.hs ? k/2 : k)];
      p.last = w.last && (k >= n-1-int'(w.hs));
      sb.push_back(p);
    end
  endtask

  task automatic drive();
    if (tx_q.size() > 0) begin
      in_valid  = 1'b1;
      in_bits   = tx_q[0].bits;
      in_hscale = tx_q[0].hs;
      in_last   = tx_q[0].last;
    end else begin
      in_valid = 1'b0;
    end
  endtask

  task automatic send(input logic [W-1:0] b,
                      input logic hs,
                      input logic last);
    word_t w;
    w.bits = b;
    w.hs   = hs;
    w.last = last;
    tx_q.push_back(w);
    drive();
  endtask

  task automatic tick();
    pix_t e;
    @(negedge clk);
    if (pix_valid && pix_en) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("pix_out", 32'(pix_out), 32'(e.pix));
        chk("pix_last", 32'(pix_last), 32'(e.last));
      end
    end else if (!pix_valid) begin
      chk("idle_out", 32'(pix_out), 0);
      chk("idle_last", 32'(pix_last), 0);
    end
    if (pix_valid) vcnt++;
    if (in_valid && in_ready && !flush) begin
      push_word(tx_q[0]);
      void'(tx_q.pop_front());
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!pix_valid && n < 10) begin
      tick();
      n++;
    end
    chk(tag, 32'(pix_valid), 1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    // T1 async reset, before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("t1_ready", 32'(in_ready), 1);
    chk("t1_valid", 32'(pix_valid), 0);
    chk("t1_out", 32'(pix_out), 0);
    chk("t1_under", 32'(underrun), 0);
    chk("t1_last", 32'(pix_last), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T2 plain word, latency and length
    pix_en = 1'b1;
    vcnt = 0;
    send(16'hA5C3, 1'b0, 1'b0);
    tick();
    chk("t2_lat0", 32'(pix_valid), 0);
    tick();
    chk("t2_lat1", 32'(pix_valid), 1);
    for (int i = 0; i < 18; i++) tick();
    chk("t2_vcnt", 32'(vcnt), 16);
    chk("t2_drain", 32'(sb.size()), 0);

    // T3 repeated pixels with last tag
    send(16'h8001, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) tick();
    chk("t3_drain", 32'(sb.size()), 0);

    // T4 back-to-back words, no gap
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'h0000, 1'b0, 1'b0);
    send(16'hF0F0, 1'b0, 1'b1);
    wait_valid("t4_start");
    for (int i = 0; i < 48; i++) begin
      chk("t4_valid", 32'(pix_valid), 1);
      if (i == 8) chk("t4_ready", 32'(in_ready), 0);
      tick();
    end
    chk("t4_end", 32'(pix_valid), 0);
    chk("t4_drain", 32'(sb.size()), 0);

    // T5 underrun pulses
    pix_en = 1'b0;
    tick();
    chk("t5_idle", 32'(underrun), 0);
    pix_en = 1'b1;
    tick();
    chk("t5_pulse1", 32'(underrun), 1);
    chk("t5_out", 32'(pix_out), 0);
    pix_en = 1'b0;
    tick();
    chk("t5_clr1", 32'(underrun), 0);
    pix_en = 1'b1;
    tick();
    chk("t5_pulse2", 32'(underrun), 1);
    tick();
    chk("t5_pulse3", 32'(underrun), 1);
    pix_en = 1'b0;
    tick();
    chk("t5_clr2", 32'(underrun), 0);
    chk("t5_valid", 32'(pix_valid), 0);

    // T6 flush mid-word with a word waiting
    pix_en = 1'b1;
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hAAAA, 1'b0, 1'b1);
    wait_valid("t6_start");
    for (int i = 0; i < 5; i++) tick();
    chk("t6_hrfull", 32'(in_ready), 0);
    tx_q.delete();
    drive();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    sb.delete();
    chk("t6_fvalid", 32'(pix_valid), 0);
    chk("t6_fready", 32'(in_ready), 1);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_fnores", 32'(pix_valid), 0);

    // T6 again with an async reset pulse between edges
    send(16'hFFFF, 1'b0, 1'b0);
    send(16'hAAAA, 1'b0, 1'b1);
    wait_valid("t6r_start");
    for (int i = 0; i < 5; i++) tick();
    chk("t6r_hrfull", 32'(in_ready), 0);
    tx_q.delete();
    drive();
    #2 rst_n = 1'b0;
    #1;
    chk("t6r_valid", 32'(pix_valid), 0);
    chk("t6r_ready", 32'(in_ready), 1);
    chk("t6r_out", 32'(pix_out), 0);
    rst_n = 1'b1;
    sb.delete();
    for (int i = 0; i < 4; i++) tick();
    chk("t6r_nores", 32'(pix_valid), 0);

    // recovery after reset: a fresh word still streams
    send(16'h3C5A, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick();
    chk("post_drain", 32'(sb.size()), 0);
    pix_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
